// File: rtl/afisor_7seg_multiplexat.sv
// Drives a common-anode 4-digit 7-segment display by time-multiplexing four BCD digits.
// Each slot starts with a short all-anodes-off gap to suppress ghosting between digits.
module afisor_7seg_multiplexat #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 4,
    parameter int DP_POS      = 2,
    parameter int BLANK_LZ    = 1,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic       clock,
    input  logic       reseteaza,
    input  logic [3:0] cifra0,
    input  logic [3:0] cifra1,
    input  logic [3:0] cifra2,
    input  logic [3:0] cifra3,
    input  logic       aprins,
    output logic [3:0] anod,
    output logic [6:0] segmente,
    output logic       punct,
    output logic       cadru_gata
);

    localparam int              DW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0]   BLANK_TH = DW'(BLANK_CYC);
    localparam logic [2:0]      DP_IDX   = 3'(DP_POS);
    localparam logic            INV      = (ACTIVE_LOW != 0);

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    logic [DW-1:0] div_cnt_reg;
    logic [DW-1:0] div_cnt_next;
    logic [1:0]    idx_reg;
    logic [1:0]    idx_next;
    logic          started_reg;
    logic          wrap;
    logic [3:0]    anod_next;
    logic          dp_next;

    logic [3:0] digit [4];
    logic [3:0] zero;
    logic [3:0] blank;
    logic [6:0] pat [4];

    assign digit[0] = cifra0;
    assign digit[1] = cifra1;
    assign digit[2] = cifra2;
    assign digit[3] = cifra3;

    // A digit above the decimal point is blanked only when it and everything left of it is zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign zero[gi] = (digit[gi] == 4'd0);
            if (BLANK_LZ != 0 && gi > DP_POS) begin : g_lz
                assign blank[gi] = &zero[3:gi];
            end else begin : g_keep
                assign blank[gi] = 1'b0;
            end
            assign pat[gi] = blank[gi] ? 7'h00 : decode(digit[gi]);
        end
    endgenerate

    always_comb begin
        wrap         = (div_cnt_reg == DIV_LAST);
        div_cnt_next = wrap ? '0 : div_cnt_reg + DW'(1);
        idx_next     = wrap ? idx_reg + 2'd1 : idx_reg;
        anod_next    = 4'b0000;
        if (aprins && div_cnt_next >= BLANK_TH) begin
            anod_next = 4'b0001 << idx_next;
        end
        dp_next      = ({1'b0, idx_next} == DP_IDX);
    end

    // Segments and decimal point are sampled once at slot start (and on the first edge out of reset).
    always_ff @(posedge clock or posedge reseteaza) begin
        if (reseteaza) begin
            div_cnt_reg <= '0;
            idx_reg     <= 2'd0;
            started_reg <= 1'b0;
            anod        <= {4{INV}};
            segmente    <= {7{INV}};
            punct       <= INV;
            cadru_gata  <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            idx_reg     <= idx_next;
            started_reg <= 1'b1;
            anod        <= anod_next ^ {4{INV}};
            cadru_gata  <= wrap && (idx_reg == 2'd3);
            if (!started_reg || wrap) begin
                segmente <= pat[idx_next] ^ {7{INV}};
                punct    <= dp_next ^ INV;
            end
        end
    end

endmodule

// File: tb/tb_afisor_7seg_multiplexat.sv
// Bench for the multiplexed display: a slot/frame arithmetic model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_afisor_7seg_multiplexat;

    localparam int R  = 8;
    localparam int B  = 2;
    localparam int DP = 2;
    localparam int LZ = 1;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cifra0, cifra1, cifra2, cifra3;
    logic       aprins;
    logic [3:0] anod;
    logic [6:0] segmente;
    logic       punct;
    logic       cadru_gata;

    int  checks = 0;
    int  errors = 0;
    bit  cmp_en = 1'b0;

    // Model state: n_m = clock edges since reset release.
    int         n_m;
    logic [3:0] e_anod;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_frame;

    afisor_7seg_multiplexat #(
        .REFRESH_DIV(R), .BLANK_CYC(B), .DP_POS(DP), .BLANK_LZ(LZ), .ACTIVE_LOW(1)
    ) dut (
        .clock(clk), .reseteaza(rst),
        .cifra0(cifra0), .cifra1(cifra1), .cifra2(cifra2), .cifra3(cifra3),
        .aprins(aprins), .anod(anod), .segmente(segmente), .punct(punct),
        .cadru_gata(cadru_gata)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model_pat(int s);
        logic [3:0] d [4];
        bit         blank;
        d[0] = cifra0; d[1] = cifra1; d[2] = cifra2; d[3] = cifra3;
        blank = 1'b0;
        if (LZ != 0 && s > DP) begin
            blank = 1'b1;
            for (int j = s; j < 4; j++) if (d[j] != 4'd0) blank = 1'b0;
        end
        return blank ? 7'h00 : SEG_TAB[d[s]];
    endfunction

    function automatic logic [3:0] onehot(int s);
        logic [3:0] v;
        v = 4'b0000;
        v[s] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n_m     <= 0;
            e_anod  <= 4'hF;
            e_seg   <= 7'h7F;
            e_dp    <= 1'b1;
            e_frame <= 1'b0;
        end else begin
            n_m     <= n_m + 1;
            e_anod  <= (aprins && ((n_m + 1) % R) >= B) ? ~onehot(((n_m + 1) / R) % 4) : 4'hF;
            e_frame <= (((n_m + 1) % (4 * R)) == 0);
            if (n_m == 0 || ((n_m + 1) % R) == 0) begin
                e_seg <= ~model_pat(((n_m + 1) / R) % 4);
                e_dp  <= ~((((n_m + 1) / R) % 4) == DP);
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_anod",  32'(anod),       32'(e_anod));
            chk("model_seg",   32'(segmente),   32'(e_seg));
            chk("model_punct", 32'(punct),      32'(e_dp));
            chk("model_frame", 32'(cadru_gata), 32'(e_frame));
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic goto_slot(int s, int d);
        int k;
        k = 0;
        do begin
            step(1);
            k++;
        end while (!(((n_m / R) % 4) == s && (n_m % R) == d) && k < 80);
        if (k >= 80) begin
            checks++;
            errors++;
            $display("FAIL goto_timeout actual=%0d required=slot%0d_div%0d", n_m, s, d);
        end
    endtask

    task automatic lit(string name, logic [3:0] a, logic [6:0] s, logic p);
        chk({name, "_anod"},  32'(anod),     32'(a));
        chk({name, "_seg"},   32'(segmente), 32'(s));
        chk({name, "_punct"}, 32'(punct),    32'(p));
        $display("%s: anod=%h seg=%h punct=%b", name, anod, segmente, punct);
    endtask

    initial begin
        int cnt, bad, nf, k;
        cifra0 = 4'd1; cifra1 = 4'd2; cifra2 = 4'd3; cifra3 = 4'd4;
        aprins = 1'b1;
        rst    = 1'b0;
        #1 rst = 1'b1;
        cmp_en = 1'b1;

        step(3);
        lit("reset_held", 4'hF, 7'h7F, 1'b1);
        chk("reset_frame", 32'(cadru_gata), 32'd0);
        rst = 1'b0;

        cnt = 0;
        for (int i = 1; i <= R; i++) begin
            step(1);
            if (i == 1) lit("first_slot", 4'hF, 7'h79, 1'b1);
            if (anod == 4'hE) cnt++;
        end
        chk("slot0_lit_cycles", cnt, R - B);

        cifra3 = 4'd0; cifra2 = 4'd0; cifra1 = 4'd5; cifra0 = 4'd9;
        goto_slot(3, 3); lit("lz_slot3", 4'h7, 7'h7F, 1'b1);
        goto_slot(2, 3); lit("dp_slot2", 4'hB, 7'h40, 1'b0);
        goto_slot(1, 3); lit("five_slot1", 4'hD, 7'h12, 1'b1);
        goto_slot(0, 3); lit("nine_slot0", 4'hE, 7'h10, 1'b1);
        cifra3 = 4'd1;
        goto_slot(3, 3); lit("one_slot3", 4'h7, 7'h79, 1'b1);

        goto_slot(1, 3);
        cifra1 = 4'd7;
        step(2);
        lit("midslot_hold", 4'hD, 7'h12, 1'b1);
        goto_slot(1, 0);
        lit("next_slot1", 4'hF, 7'h78, 1'b1);

        cifra0 = 4'hC;
        goto_slot(0, 3); lit("dash_slot0", 4'hE, 7'h3F, 1'b1);

        goto_slot(0, 1);
        aprins = 1'b0;
        bad = 0; nf = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (anod != 4'hF) bad++;
            if (cadru_gata) nf++;
        end
        chk("dark_anod_active", bad, 0);
        chk("dark_frames", nf, 1);
        $display("dark: 40 cycles anod_active=%0d frames=%0d", bad, nf);
        aprins = 1'b1;
        goto_slot(0, 3); lit("resume_slot0", 4'hE, 7'h3F, 1'b1);

        goto_slot(2, 5);
        rst = 1'b1;
        #1;
        lit("async_reset", 4'hF, 7'h7F, 1'b1);
        chk("async_reset_frame", 32'(cadru_gata), 32'd0);
        step(2);
        rst = 1'b0;
        step(1);
        lit("after_reset", 4'hF, 7'h3F, 1'b1);
        k = 1;
        while (!cadru_gata && k < 100) begin
            step(1);
            k++;
        end
        chk("first_frame_delay", k, 4 * R);
        $display("after_reset: first cadru_gata after %0d cycles", k);

        step(2);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
